// File: rtl/cam_bitmap_core.sv
// rtl/cam_bitmap_core.sv - bitmap CAM with two-cycle erase/set writes; optional CAM_MULTI_MATCH_EN
module cam_bitmap_core #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] cmp_din,
  output logic                  busy,
  output logic                  match,
  output logic [ADDR_WIDTH-1:0] match_addr
`ifdef CAM_MULTI_MATCH_EN
  ,
  output logic                  multi_match
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int ROWS  = 1 << DATA_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SET  = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] lat_din;
  logic [ADDR_WIDTH-1:0] lat_addr;

  // One row per data value; bit a set means address a currently holds that value.
  logic [DEPTH-1:0]      bitmap [ROWS];
  // Shadow copy of each address's word so the old row can be found on overwrite.
  logic [DATA_WIDTH-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic [DEPTH-1:0]      row;
  logic [ADDR_WIDTH-1:0] enc;

  assign busy = (state == SET);
  assign row  = bitmap[cmp_din];

  // Write sequencer: erase the old row bit on acceptance, set the new one on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_din  <= '0;
      lat_addr <= '0;
      valid    <= '0;
      for (int r = 0; r < ROWS; r++) begin
        bitmap[r] <= '0;
      end
      for (int a = 0; a < DEPTH; a++) begin
        shadow[a] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (write_enable) begin
            lat_din  <= din;
            lat_addr <= write_addr;
            if (valid[write_addr]) begin
              bitmap[shadow[write_addr]][write_addr] <= 1'b0;
            end
            state <= SET;
          end
        end
        SET: begin
          bitmap[lat_din][lat_addr] <= 1'b1;
          shadow[lat_addr]          <= lat_din;
          valid[lat_addr]           <= 1'b1;
          state                     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Priority encoder: lowest set bit of the selected row wins; 0 when the row is empty.
  always_comb begin
    enc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (row[i]) begin
        enc = i[ADDR_WIDTH-1:0];
      end
    end
  end

`ifdef CAM_MULTI_MATCH_EN
  // Compare result register; row & (row-1) is non-zero only when two or more bits are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match       <= 1'b0;
      match_addr  <= '0;
      multi_match <= 1'b0;
    end else begin
      match       <= |row;
      match_addr  <= enc;
      multi_match <= |(row & (row - DEPTH'(1)));
    end
  end
`else
  // Compare result register, sampled from the bitmap as it stood before this edge's write update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match      <= 1'b0;
      match_addr <= '0;
    end else begin
      match      <= |row;
      match_addr <= enc;
    end
  end
`endif

endmodule

// File: tb/tb_cam_bitmap_core.sv
// tb/tb_cam_bitmap_core.sv - table-driven bench for cam_bitmap_core
module tb_cam_bitmap_core;

  logic       clk;
  logic       rst;
  logic       write_enable;
  logic [3:0] din;
  logic [1:0] write_addr;
  logic [3:0] cmp_din;
  logic       busy;
  logic       match;
  logic [1:0] match_addr;
`ifdef CAM_MULTI_MATCH_EN
  logic       multi_match;
`endif

  int checks;
  int errors;

  cam_bitmap_core #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .din          (din),
    .write_addr   (write_addr),
    .cmp_din      (cmp_din),
    .busy         (busy),
    .match        (match),
    .match_addr   (match_addr)
`ifdef CAM_MULTI_MATCH_EN
    ,
    .multi_match  (multi_match)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [3:0] data;
    logic       exp_match;
    logic [1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w, logic [1:0] a, logic [3:0] d, logic m, logic [1:0] ea);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp_match = m; v.exp_addr = ea;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Single write; busy must be high for exactly the cycle after acceptance.
  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    write_enable = 1'b1;
    write_addr   = a;
    din          = d;
    tick();
    check("wr_busy_hi", {7'd0, busy}, 8'd1);
    write_enable = 1'b0;
    tick();
    check("wr_busy_lo", {7'd0, busy}, 8'd0);
  endtask

  task automatic search(input logic [3:0] d, input logic m, input logic [1:0] ea, input int idx);
    cmp_din = d;
    tick();
    check($sformatf("srch%0d_match", idx), {7'd0, match}, {7'd0, m});
    check($sformatf("srch%0d_addr", idx), {6'd0, match_addr}, {6'd0, ea});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    write_enable = 1'b0;
    din = '0;
    write_addr = '0;
    cmp_din = '0;

    // Fill and search
    vecs.push_back(mk(1, 2'd0, 4'd3,  0, 2'd0));
    vecs.push_back(mk(1, 2'd1, 4'd7,  0, 2'd0));
    vecs.push_back(mk(1, 2'd2, 4'd12, 0, 2'd0));
    vecs.push_back(mk(1, 2'd3, 4'd5,  0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd12, 1, 2'd2));
    vecs.push_back(mk(0, 2'd0, 4'd6,  0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd3,  1, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd5,  1, 2'd3));
    vecs.push_back(mk(0, 2'd0, 4'd7,  1, 2'd1));
    // Duplicate priority
    vecs.push_back(mk(1, 2'd1, 4'd9,  0, 2'd0));
    vecs.push_back(mk(1, 2'd3, 4'd9,  0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd9,  1, 2'd1));
    vecs.push_back(mk(1, 2'd1, 4'd4,  0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd9,  1, 2'd3));
    vecs.push_back(mk(0, 2'd0, 4'd4,  1, 2'd1));
    vecs.push_back(mk(0, 2'd0, 4'd7,  0, 2'd0));
    // Overwrite erases old value (contents end as 0:3 1:4 2:9 3:9)
    vecs.push_back(mk(1, 2'd2, 4'd15, 0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd15, 1, 2'd2));
    vecs.push_back(mk(1, 2'd2, 4'd9,  0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd15, 0, 2'd0));
    vecs.push_back(mk(0, 2'd0, 4'd9,  1, 2'd2));
    vecs.push_back(mk(0, 2'd0, 4'd12, 0, 2'd0));

    // Reset and empty search
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_match", {7'd0, match}, 8'd0);
    check("rst_addr", {6'd0, match_addr}, 8'd0);
    rst = 1'b1;
    search(4'd0, 1'b0, 2'd0, 100);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               search(vecs[i].data, vecs[i].exp_match, vecs[i].exp_addr, i);
    end

`ifdef CAM_MULTI_MATCH_EN
    cmp_din = 4'd9;
    tick();
    check("multi_9", {7'd0, multi_match}, 8'd1);
    cmp_din = 4'd3;
    tick();
    check("multi_3", {7'd0, multi_match}, 8'd0);
`endif

    // Rewrite same value: net unchanged
    do_write(2'd0, 4'd3);
    search(4'd3, 1'b1, 2'd0, 101);

    // Compare held through an overwrite of address 0 (3 -> 15)
    cmp_din = 4'd3;
    tick();
    check("hold_base", {7'd0, match}, 8'd1);
    write_enable = 1'b1;
    write_addr   = 2'd0;
    din          = 4'd15;
    tick();
    check("hold_erase_busy", {7'd0, busy}, 8'd1);
    check("hold_erase_match", {7'd0, match}, 8'd1);
    write_enable = 1'b0;
    tick();
    check("hold_set_busy", {7'd0, busy}, 8'd0);
    check("hold_set_match", {7'd0, match}, 8'd0);
    tick();
    check("hold_after_match", {7'd0, match}, 8'd0);
    search(4'd15, 1'b1, 2'd0, 102);

    // Busy blocking: write_enable held 4 cycles -> two writes
    write_enable = 1'b1;
    write_addr   = 2'd0;
    din          = 4'd13;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("blk_busy%0d", c), {7'd0, busy}, (c % 2 == 0) ? 8'd1 : 8'd0);
    end
    write_enable = 1'b0;
    search(4'd13, 1'b1, 2'd0, 103);
    search(4'd15, 1'b0, 2'd0, 104);

    // Async reset mid-write of 6@1
    cmp_din = 4'd13;
    write_enable = 1'b1;
    write_addr   = 2'd1;
    din          = 4'd6;
    tick();
    write_enable = 1'b0;
    check("ar_busy_pre", {7'd0, busy}, 8'd1);
    check("ar_match_pre", {7'd0, match}, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy_now", {7'd0, busy}, 8'd0);
    check("ar_match_now", {7'd0, match}, 8'd0);
    check("ar_addr_now", {6'd0, match_addr}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    search(4'd6, 1'b0, 2'd0, 105);
    search(4'd13, 1'b0, 2'd0, 106);
    search(4'd0, 1'b0, 2'd0, 107);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_bitmap_core.md
Name: cam_bitmap_core

Overview:
- Small RAM-style content-addressable memory.
- Stores one DATA_WIDTH word per address. Searches all addresses for a compare word and returns a hit flag plus the lowest matching address.
- Internally kept as a bitmap per data value (2^DATA_WIDTH rows × 2^ADDR_WIDTH bits), with a shadow word/valid store per address.
- A write is a two-cycle erase-then-set sequence, flagged by busy. Used as a lookup table behind a simple write/compare interface.

Parameters:
- DATA_WIDTH, 4, width of stored and compared words.
- ADDR_WIDTH, 2, address width; depth = 2^ADDR_WIDTH entries.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous and active-low (asserted at 0).
- write_enable  in  1  write request; sampled only when busy=0.
- din  in  DATA_WIDTH  write data.
- write_addr  in  ADDR_WIDTH  write address.
- cmp_din  in  DATA_WIDTH  compare (search) word, sampled every cycle.
- busy  out  1  write sequence in progress; new writes ignored.
- match  out  1  registered hit flag for the previous cycle's cmp_din.
- match_addr  out  ADDR_WIDTH  lowest matching address; 0 when match=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - All bitmap rows cleared; all valid bits cleared; shadow words cleared.
  - FSM goes to IDLE.
  - Outputs: busy=0, match=0, match_addr=0.
- Reset mid-write aborts the write; no partial entry survives.
- FSM states are IDLE and SET.
- IDLE:
  - On a rising edge with write_enable=1, latch din and write_addr.
  - If valid[write_addr]=1, clear bit write_addr in bitmap[shadow[write_addr]] (erase old content).
  - Go to SET; busy=1 from this edge.
- SET:
  - Next edge: set bit addr in bitmap[latched din], write shadow[addr]=latched din, set valid[addr]=1.
  - Return to IDLE; busy=0 from this edge.
- Write timing:
  - One write every 2 cycles maximum.
  - write_enable held high continuously starts a new write every other cycle, on each edge where busy=0.
  - write_enable and inputs are ignored while busy=1.
- Compare:
  - Every edge registers match = OR(bitmap[cmp_din]) using bitmap contents before that edge's update.
  - match_addr = index of the lowest set bit of that row (priority encoder), else 0.
  - Latency is 1 cycle.
- Write/compare overlap:
  - From the erase edge onward, the old value at the written address no longer hits.
  - The new value hits on a compare sampled at the edge after the SET edge; its result is visible 1 cycle after that.
- Duplicates:
  - The same value may be stored at several addresses; the lowest address is reported.
  - Rewriting an address with its current value is legal: erase then set, net unchanged.
- Never-written addresses never match, including for cmp_din=0 after reset.
- All arithmetic is unsigned; no wrap conditions exist. Every address is always writable (no full/empty state).

Optional Feature:
- Macro CAM_MULTI_MATCH_EN.
- When defined: extra output multi_match (1 bit), registered alongside match.
  - Equals 1 when two or more bits of bitmap[cmp_din] are set.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and empty search: assert rst=0 for 2 cycles, release; cmp_din=0 → match=0, match_addr=0, busy=0.
- Fill and search:
  - Write 3@0, 7@1, 12@2, 5@3, each write_enable pulse followed by waiting for busy=0.
  - busy is high exactly 1 cycle per write.
  - cmp_din=12 → next cycle match=1, match_addr=2.
  - cmp_din=6 → match=0, match_addr=0.
- Duplicate priority:
  - Write 9@1 and 9@3; cmp_din=9 → match_addr=1.
  - Overwrite address 1 with 4; cmp_din=9 → match_addr=3; cmp_din=4 → match_addr=1.
- Overwrite erases old value:
  - Write 15@2, then 9@2; cmp_din=15 → match=0; cmp_din=9 → match=1, match_addr=2.
  - cmp_din=15 held through the write shows the hit dropping on the erase edge.
- Busy blocking: hold write_enable=1 with din=13, write_addr=0 for 4 cycles → exactly 2 writes accepted (busy toggles 1,0,1,0); final content 13@0.
- Async reset mid-write:
  - Pull rst low while busy=1 during a write of 6@1.
  - busy and match clear immediately, without waiting for a clock edge.
  - After release, cmp_din=6 → match=0.
